ldm_stm_sequencer: RTL and testbench

//  Multicycle sequencer for ARM LDM/STM (IA/IB/DA/DB, optional writeback). Sits beside the

---
 rtl/ldm_stm_sequencer_pkg.sv | 32 +++
 rtl/ldm_stm_sequencer_if.sv | 16 +
 rtl/ldm_stm_sequencer_lowest_set_bit.sv | 22 ++
 rtl/ldm_stm_sequencer.sv | 147 ++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM sequencer: FSM state encoding, addressing
// modes decoded from {P,U}, word size and a 16-bit population count.
package ldm_stm_sequencer_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StWb   = 2'd2,
    StDone = 2'd3
  } state_e;

  // Encoded as {p_bit, u_bit}.
  typedef enum logic [1:0] {
    ModeDa = 2'b00,
    ModeIa = 2'b01,
    ModeDb = 2'b10,
    ModeIb = 2'b11
  } amode_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_if.sv
// Data-memory word access bus.
//   master (sequencer): drives req/we/addr/wdata, receives rdata/ack
//   slave  (memory)   : the reverse
interface ldm_stm_sequencer_if #(
  parameter int unsigned DW = 32
);
  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/ldm_stm_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a 16-bit vector.
//   vec   in  16  vector to scan
//   idx   out 4   index of lowest set bit (0 when vec is zero)
//   valid out 1   vec is non-zero
module ldm_stm_sequencer_lowest_set_bit (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multicycle LDM/STM sequencer. Launched by start while idle, issues one word
// access per listed register (lowest register at lowest address), then an
// optional base writeback cycle and a one-cycle done pulse.
//   clk, reset                 clock, synchronous active-high reset
//   start/load/p_bit/u_bit/w_bit/rn/base/reglist   launch command
//   rf_ra2/rf_rd2              register read port for store data
//   rf_we3/rf_wa3/rf_wd3       loaded-register write port
//   rf_we4/rf_wa4/rf_wd4       base writeback port
//   pc_we/pc_wd                load into r15
//   mem                        data-memory bus (master side)
//   busy, done                 status
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load,
  input  logic            p_bit,
  input  logic            u_bit,
  input  logic            w_bit,
  input  logic [3:0]      rn,
  input  logic [DW-1:0]   base,
  input  logic [NREG-1:0] reglist,
  input  logic [DW-1:0]   rf_rd2,
  output logic [3:0]      rf_ra2,
  output logic            rf_we3,
  output logic [3:0]      rf_wa3,
  output logic [DW-1:0]   rf_wd3,
  output logic            rf_we4,
  output logic [3:0]      rf_wa4,
  output logic [DW-1:0]   rf_wd4,
  output logic            pc_we,
  output logic [DW-1:0]   pc_wd,
  ldm_stm_sequencer_if.master mem,
  output logic            busy,
  output logic            done
);

  localparam logic [DW-1:0] Word = DW'(WORD_BYTES);

  state_e          state_q;
  logic [NREG-1:0] pending_q;
  logic [DW-1:0]   addr_q;
  logic [DW-1:0]   wb_q;
  logic            load_q;
  logic            wb_en_q;
  logic [3:0]      rn_q;

  logic [IDX_W-1:0] cur;
  logic             cur_valid;
  logic [NREG-1:0]  pending_next;
  logic [4:0]       n_words;
  logic [DW-1:0]    span;
  logic [DW-1:0]    start_addr;
  logic [DW-1:0]    wb_val;
  logic             in_xfer;
  logic             ack_ld;

  ldm_stm_sequencer_lowest_set_bit u_lsb (
    .vec   (pending_q),
    .idx   (cur),
    .valid (cur_valid)
  );

  assign pending_next = pending_q & ~({{(NREG-1){1'b0}}, 1'b1} << cur);

  // Launch-time address arithmetic, modulo 2^DW.
  always_comb begin
    n_words    = popcount16(reglist);
    span       = DW'({n_words, 2'b00});
    start_addr = base;
    unique case (amode_e'({p_bit, u_bit}))
      ModeIa: start_addr = base;
      ModeIb: start_addr = base + Word;
      ModeDa: start_addr = base - span + Word;
      ModeDb: start_addr = base - span;
    endcase
    wb_val = u_bit ? base + span : base - span;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= '0;
      addr_q    <= '0;
      wb_q      <= '0;
      load_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      rn_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pending_q <= reglist;
            addr_q    <= start_addr;
            wb_q      <= wb_val;
            load_q    <= load;
            rn_q      <= rn;
            // Loaded base wins over writeback; r15 writeback is dropped.
            wb_en_q   <= w_bit && !(load && reglist[rn]) && (rn != 4'd15);
            state_q   <= (reglist == '0) ? StDone : StXfer;
          end
        end
        StXfer: begin
          if (mem.ack) begin
            pending_q <= pending_next;
            addr_q    <= addr_q + Word;
            if (pending_next == '0) begin
              state_q <= StWb;
            end
          end
        end
        StWb:    state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Enables are also masked by reset so an abort never lets one more write slip out.
  assign in_xfer   = (state_q == StXfer) && cur_valid && !reset;
  assign ack_ld    = in_xfer && mem.ack && load_q;

  assign mem.req   = in_xfer;
  assign mem.we    = in_xfer && !load_q;
  assign mem.addr  = in_xfer ? addr_q : '0;
  assign mem.wdata = in_xfer ? rf_rd2 : '0;
  assign rf_ra2    = in_xfer ? cur : '0;

  assign rf_we3    = ack_ld && (cur != 4'd15);
  assign rf_wa3    = rf_we3 ? cur : '0;
  assign rf_wd3    = rf_we3 ? mem.rdata : '0;
  assign pc_we     = ack_ld && (cur == 4'd15);
  assign pc_wd     = pc_we ? mem.rdata : '0;

  assign rf_we4    = (state_q == StWb) && wb_en_q && !reset;
  assign rf_wa4    = rf_we4 ? rn_q : '0;
  assign rf_wd4    = rf_we4 ? wb_q : '0;

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
module tb_ldm_stm_sequencer;
  import ldm_stm_sequencer_pkg::*;

  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        reset, start, load, p_bit, u_bit, w_bit;
  logic [3:0]  rn;
  logic [31:0] base;
  logic [15:0] reglist;
  logic [31:0] rf_rd2;
  logic [3:0]  rf_ra2;
  logic        rf_we3, rf_we4, pc_we, busy, done;
  logic [3:0]  rf_wa3, rf_wa4;
  logic [31:0] rf_wd3, rf_wd4, pc_wd;

  logic [31:0] regs [16];
  logic [31:0] mem_model [256];
  int n_checks = 0;
  int n_fail   = 0;
  int we3_cnt  = 0;
  int we4_cnt  = 0;
  int req_cnt  = 0;

  ldm_stm_sequencer_if #(.DW(DW)) mem_if ();

  always #5 clk = ~clk;

  // Register file and memory models answer combinationally.
  assign rf_rd2       = regs[rf_ra2];
  assign mem_if.rdata = mem_model[mem_if.addr[9:2]];

  always @(negedge clk) begin
    if (rf_we3) we3_cnt++;
    if (rf_we4) we4_cnt++;
    if (mem_if.req) req_cnt++;
  end

  ldm_stm_sequencer #(.DW(DW), .NREG(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .load    (load),
    .p_bit   (p_bit),
    .u_bit   (u_bit),
    .w_bit   (w_bit),
    .rn      (rn),
    .base    (base),
    .reglist (reglist),
    .rf_rd2  (rf_rd2),
    .rf_ra2  (rf_ra2),
    .rf_we3  (rf_we3),
    .rf_wa3  (rf_wa3),
    .rf_wd3  (rf_wd3),
    .rf_we4  (rf_we4),
    .rf_wa4  (rf_wa4),
    .rf_wd4  (rf_wd4),
    .pc_we   (pc_we),
    .pc_wd   (pc_wd),
    .mem     (mem_if.master),
    .busy    (busy),
    .done    (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic l, input logic p, input logic u, input logic w,
                        input logic [3:0] r, input logic [31:0] b, input logic [15:0] list);
    load = l; p_bit = p; u_bit = u; w_bit = w; rn = r; base = b; reglist = list;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " req"}, mem_if.req, 1'b0);
    chk({tag, " we3"}, rf_we3, 1'b0);
    chk({tag, " we4"}, rf_we4, 1'b0);
    chk({tag, " pcwe"}, pc_we, 1'b0);
    chk({tag, " addr"}, mem_if.addr, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'h5000_0000 + 32'(i * 4);
    reset = 1'b1; start = 1'b0; load = 1'b0; p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b0;
    rn = '0; base = '0; reglist = '0; mem_if.ack = 1'b0;

    step(); step();
    chk_idle("reset held");
    reset = 1'b0;
    step();
    chk_idle("after reset");

    // 1: LDMIA r0!, {r1,r2,r5}, base 0x100, immediate ack.
    mem_if.ack = 1'b1;
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h0026);
    chk("t1 c1 req", mem_if.req, 1'b1);
    chk("t1 c1 we", mem_if.we, 1'b0);
    chk("t1 c1 addr", mem_if.addr, 32'h100);
    chk("t1 c1 we3", rf_we3, 1'b1);
    chk("t1 c1 wa3", rf_wa3, 4'd1);
    chk("t1 c1 wd3", rf_wd3, 32'h5000_0100);
    step();
    chk("t1 c2 addr", mem_if.addr, 32'h104);
    chk("t1 c2 wa3", rf_wa3, 4'd2);
    chk("t1 c2 wd3", rf_wd3, 32'h5000_0104);
    step();
    chk("t1 c3 addr", mem_if.addr, 32'h108);
    chk("t1 c3 wa3", rf_wa3, 4'd5);
    chk("t1 c3 wd3", rf_wd3, 32'h5000_0108);
    step();
    chk("t1 c4 req", mem_if.req, 1'b0);
    chk("t1 c4 we4", rf_we4, 1'b1);
    chk("t1 c4 wa4", rf_wa4, 4'd0);
    chk("t1 c4 wd4", rf_wd4, 32'h10C);
    chk("t1 c4 done", done, 1'b0);
    step();
    chk("t1 c5 done", done, 1'b1);
    chk("t1 c5 busy", busy, 1'b1);
    chk("t1 c5 we4", rf_we4, 1'b0);
    step();
    chk_idle("t1 c6");

    // 2a: STMDB r13!, {r4,r14}, base 0x200.
    launch(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h4010);
    chk("t2a c1 we", mem_if.we, 1'b1);
    chk("t2a c1 addr", mem_if.addr, 32'h1F8);
    chk("t2a c1 ra2", rf_ra2, 4'd4);
    chk("t2a c1 wdata", mem_if.wdata, 32'hA000_0004);
    chk("t2a c1 we3", rf_we3, 1'b0);
    step();
    chk("t2a c2 addr", mem_if.addr, 32'h1FC);
    chk("t2a c2 ra2", rf_ra2, 4'd14);
    chk("t2a c2 wdata", mem_if.wdata, 32'hA000_000E);
    step();
    chk("t2a wb we4", rf_we4, 1'b1);
    chk("t2a wb wa4", rf_wa4, 4'd13);
    chk("t2a wb wd4", rf_wd4, 32'h1F8);
    step(); step();
    chk_idle("t2a end");

    // 2b: STMIB base 0x40, {r0,r1}, no writeback.
    launch(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'h40, 16'h0003);
    chk("t2b c1 addr", mem_if.addr, 32'h44);
    chk("t2b c1 wdata", mem_if.wdata, 32'hA000_0000);
    step();
    chk("t2b c2 addr", mem_if.addr, 32'h48);
    chk("t2b c2 wdata", mem_if.wdata, 32'hA000_0001);
    step();
    chk("t2b wb we4", rf_we4, 1'b0);
    step(); step();
    chk_idle("t2b end");

    // 2c: LDMDA base 0x40, {r0,r1}.
    launch(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h40, 16'h0003);
    chk("t2c c1 addr", mem_if.addr, 32'h3C);
    chk("t2c c1 wa3", rf_wa3, 4'd0);
    chk("t2c c1 wd3", rf_wd3, 32'h5000_003C);
    step();
    chk("t2c c2 addr", mem_if.addr, 32'h40);
    chk("t2c c2 wa3", rf_wa3, 4'd1);
    step(); step(); step();
    chk_idle("t2c end");

    // 3a: LDMIA r3!, {r3,r4}: loaded base suppresses writeback.
    mem_model[8'h30] = 32'hAA;
    mem_model[8'h31] = 32'hBB;
    we4_cnt = 0;
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'hC0, 16'h0018);
    chk("t3a c1 wa3", rf_wa3, 4'd3);
    chk("t3a c1 wd3", rf_wd3, 32'hAA);
    step();
    chk("t3a c2 wa3", rf_wa3, 4'd4);
    chk("t3a c2 wd3", rf_wd3, 32'hBB);
    step(); step(); step();
    chk_idle("t3a end");
    chk("t3a we4 count", 32'(we4_cnt), 32'd0);

    // 3b: STMIA r3!, {r3}, base 0x80: original base stored, then writeback.
    regs[3] = 32'h80;
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h80, 16'h0008);
    chk("t3b c1 addr", mem_if.addr, 32'h80);
    chk("t3b c1 wdata", mem_if.wdata, 32'h80);
    step();
    chk("t3b wb we4", rf_we4, 1'b1);
    chk("t3b wb wa4", rf_wa4, 4'd3);
    chk("t3b wb wd4", rf_wd4, 32'h84);
    step(); step();
    chk_idle("t3b end");

    // 4: LDMIA {r6,r8} base 0x10, ack on the third cycle of each access,
    // with start pulses while busy.
    mem_if.ack = 1'b0;
    we3_cnt = 0;
    launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h10, 16'h0140);
    chk("t4 c1 addr", mem_if.addr, 32'h10);
    chk("t4 c1 we3", rf_we3, 1'b0);
    base = 32'h300; reglist = 16'hFFFF; start = 1'b1;
    step();
    chk("t4 c2 addr", mem_if.addr, 32'h10);
    chk("t4 c2 ra2", rf_ra2, 4'd6);
    chk("t4 c2 we3", rf_we3, 1'b0);
    step();
    start = 1'b0;
    chk("t4 c3 addr", mem_if.addr, 32'h10);
    mem_if.ack = 1'b1;
    #1;
    chk("t4 c3 we3", rf_we3, 1'b1);
    chk("t4 c3 wa3", rf_wa3, 4'd6);
    chk("t4 c3 wd3", rf_wd3, 32'h5000_0010);
    step();
    mem_if.ack = 1'b0;
    #1;
    chk("t4 c4 addr", mem_if.addr, 32'h14);
    chk("t4 c4 we3", rf_we3, 1'b0);
    step();
    chk("t4 c5 ra2", rf_ra2, 4'd8);
    step();
    mem_if.ack = 1'b1;
    #1;
    chk("t4 c6 wa3", rf_wa3, 4'd8);
    chk("t4 c6 wd3", rf_wd3, 32'h5000_0014);
    step();
    mem_if.ack = 1'b0;
    chk("t4 c7 req", mem_if.req, 1'b0);
    start = 1'b1;
    step();
    chk("t4 c8 done", done, 1'b1);
    start = 1'b0;
    step();
    chk_idle("t4 end");
    chk("t4 we3 count", 32'(we3_cnt), 32'd2);

    // 5: reset after the first of four LDM transfers.
    mem_if.ack = 1'b1;
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h20, 16'h001E);
    chk("t5 c1 wa3", rf_wa3, 4'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("t5 after reset");
    we3_cnt = 0; we4_cnt = 0; req_cnt = 0;
    step(); step(); step();
    chk("t5 req count", 32'(req_cnt), 32'd0);
    chk("t5 we3 count", 32'(we3_cnt), 32'd0);
    chk("t5 we4 count", 32'(we4_cnt), 32'd0);
    launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h30, 16'h0080);
    chk("t5 r7 addr", mem_if.addr, 32'h30);
    chk("t5 r7 wa3", rf_wa3, 4'd7);
    chk("t5 r7 wd3", rf_wd3, 32'h5000_0030);
    step(); step();
    chk("t5 r7 done", done, 1'b1);
    step();
    chk_idle("t5 r7 end");

    // 6a: empty list.
    req_cnt = 0; we4_cnt = 0;
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h60, 16'h0000);
    chk("t6a done", done, 1'b1);
    chk("t6a busy", busy, 1'b1);
    step();
    chk_idle("t6a end");
    chk("t6a req count", 32'(req_cnt), 32'd0);
    chk("t6a we4 count", 32'(we4_cnt), 32'd0);

    // 6b: LDMIA {r15}.
    launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h50, 16'h8000);
    chk("t6b pc_we", pc_we, 1'b1);
    chk("t6b pc_wd", pc_wd, 32'h5000_0050);
    chk("t6b we3", rf_we3, 1'b0);
    step(); step(); step();
    chk_idle("t6b end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
